// File: rtl/mul_sched_if.sv
// Requester and multiplier-facing signal bundle for the shared-multiplier scheduler.
// The slave modport is the scheduler's view; master is the requester/multiplier side.
interface mul_sched_if #(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4
);
  logic [NREQ-1:0]          req;
  logic [NREQ*BITWIDTH-1:0] din1_bus;
  logic [NREQ*BITWIDTH-1:0] din2_bus;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          done;
  logic [BITWIDTH-1:0]      result;
  logic                     err;
  logic                     busy;
  logic                     mul_in_valid;
  logic [BITWIDTH-1:0]      mul_din1;
  logic [BITWIDTH-1:0]      mul_din2;
  logic                     mul_out_valid;
  logic [BITWIDTH-1:0]      mul_dout;

  modport slave (
    input  req, din1_bus, din2_bus, mul_out_valid, mul_dout,
    output gnt, done, result, err, busy, mul_in_valid, mul_din1, mul_din2
  );

  modport master (
    output req, din1_bus, din2_bus, mul_out_valid, mul_dout,
    input  gnt, done, result, err, busy, mul_in_valid, mul_din1, mul_din2
  );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier among NREQ requesters,
// with a watchdog that abandons an operation whose result never arrives.
module mul_sched #(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 4*BITWIDTH
) (
  input logic        clk,
  input logic        rst,
  mul_sched_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW  = $clog2(TIMEOUT+1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                miv_q, miv_d;
  logic [BITWIDTH-1:0] result_q, result_d;
  logic [BITWIDTH-1:0] din1_q, din1_d;
  logic [BITWIDTH-1:0] din2_q, din2_d;

  logic                found;
  logic [IDW-1:0]      win;

  // Arbitration: first asserted request strictly after the last winner, with wrap.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    timer_d  = timer_q;
    result_d = result_q;
    din1_d   = din1_q;
    din2_d   = din2_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    miv_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d       = win;
          din1_d     = bus.din1_bus[int'(win)*BITWIDTH +: BITWIDTH];
          din2_d     = bus.din2_bus[int'(win)*BITWIDTH +: BITWIDTH];
          gnt_d[win] = 1'b1;
          miv_d      = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle itself still wins.
        if (bus.mul_out_valid) begin
          result_d     = bus.mul_dout;
          done_d[id_q] = 1'b1;
          state_d      = S_RETURN;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          result_d     = '0;
          done_d[id_q] = 1'b1;
          err_d        = 1'b1;
          state_d      = S_RETURN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RETURN: begin
        ptr_d   = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Outputs are registered on the transition into the state that presents them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDW'(NREQ-1);
      id_q     <= '0;
      timer_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      miv_q    <= 1'b0;
      result_q <= '0;
      din1_q   <= '0;
      din2_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      timer_q  <= timer_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      miv_q    <= miv_d;
      result_q <= result_d;
      din1_q   <= din1_d;
      din2_q   <= din2_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;
  assign bus.mul_in_valid = miv_q;
  assign bus.result       = result_q;
  assign bus.mul_din1     = din1_q;
  assign bus.mul_din2     = din2_q;

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched: directed requests, a behavioural multiplier with
// fixed latency, and monitors that pop expected grants/results as the DUT emits them.
module tb_mul_sched;
  localparam int BW  = 8;
  localparam int NR  = 4;
  localparam int TO  = 4*BW;
  localparam int LAT = BW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mul_sched_if #(.BITWIDTH(BW), .NREQ(NR)) bus();

  mul_sched #(.BITWIDTH(BW), .NREQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural multiplier: result valid LAT cycles after the start strobe is sampled.
  logic          mute = 1'b0;
  logic          model_vld;
  logic [BW-1:0] model_dout, ma, mb;
  int            mcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_vld  <= 1'b0;
      model_dout <= '0;
      ma         <= '0;
      mb         <= '0;
      mcnt       <= 0;
    end else begin
      model_vld <= 1'b0;
      if (bus.mul_in_valid && !mute) begin
        ma   <= bus.mul_din1;
        mb   <= bus.mul_din2;
        mcnt <= LAT-1;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          model_vld  <= 1'b1;
          model_dout <= ma * mb;
        end
      end
    end
  end

  logic          spur_vld  = 1'b0;
  logic [BW-1:0] spur_dout = '0;
  assign bus.mul_out_valid = model_vld | spur_vld;
  assign bus.mul_dout      = spur_vld ? spur_dout : model_dout;

  typedef struct { int id; logic [BW-1:0] a; logic [BW-1:0] b; } gexp_t;
  typedef struct { int id; logic [BW-1:0] res; logic err; } dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, gnt_cnt = 0, done_cnt = 0, gnt_cyc = 0, done_cyc = 0, busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.busy) busy_cnt++;
  end

  // Grant monitor
  initial begin : gmon
    gexp_t ge;
    forever begin
      @(negedge clk);
      if (rst && (bus.gnt != '0 || bus.mul_in_valid)) begin
        gnt_cnt++;
        gnt_cyc = cyc;
        if (gq.size() == 0) begin
          check("unexpected_gnt", {28'b0, bus.gnt}, 32'd0);
        end else begin
          ge = gq.pop_front();
          check("gnt_id", {28'b0, bus.gnt}, 32'd1 << ge.id);
          check("mul_in_valid", {31'b0, bus.mul_in_valid}, 32'd1);
          check("mul_din1", {24'b0, bus.mul_din1}, {24'b0, ge.a});
          check("mul_din2", {24'b0, bus.mul_din2}, {24'b0, ge.b});
        end
      end
    end
  end

  // Result monitor
  initial begin : dmon
    dexp_t de;
    forever begin
      @(negedge clk);
      if (rst && (bus.done != '0 || bus.err)) begin
        done_cnt++;
        done_cyc = cyc;
        if (dq.size() == 0) begin
          check("unexpected_done", {28'b0, bus.done}, 32'd0);
        end else begin
          de = dq.pop_front();
          check("done_id", {28'b0, bus.done}, 32'd1 << de.id);
          check("result", {24'b0, bus.result}, {24'b0, de.res});
          check("err", {31'b0, bus.err}, {31'b0, de.err});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_gnts(input int target, input string name);
    int b = 0;
    while (gnt_cnt < target && b < 400) begin
      @(negedge clk); #1;
      b++;
    end
    if (gnt_cnt < target) check(name, gnt_cnt, target);
  endtask

  task automatic wait_dones(input int target, input string name);
    int b = 0;
    while (done_cnt < target && b < 400) begin
      @(negedge clk); #1;
      b++;
    end
    if (done_cnt < target) check(name, done_cnt, target);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt",    {28'b0, bus.gnt}, 32'd0);
    check("rst_done",   {28'b0, bus.done}, 32'd0);
    check("rst_err",    {31'b0, bus.err}, 32'd0);
    check("rst_busy",   {31'b0, bus.busy}, 32'd0);
    check("rst_miv",    {31'b0, bus.mul_in_valid}, 32'd0);
    check("rst_result", {24'b0, bus.result}, 32'd0);
    check("rst_din1",   {24'b0, bus.mul_din1}, 32'd0);
    check("rst_din2",   {24'b0, bus.mul_din2}, 32'd0);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic set_op(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
    bus.din1_bus[i*BW +: BW] = a;
    bus.din2_bus[i*BW +: BW] = b;
  endtask

  task automatic expect_op(input int id, input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic [BW-1:0] res, input logic e);
    gq.push_back('{id: id, a: a, b: b});
    dq.push_back('{id: id, res: res, err: e});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int g0, d0;
    logic [BW-1:0] opa [NR];
    logic [BW-1:0] opb [NR];
    logic [BW-1:0] prd [NR];
    opa = '{8'd4, 8'd35, 8'd3,  8'd13};
    opb = '{8'd5, 8'd2,  8'd64, 8'd14};
    prd = '{8'd20, 8'd70, 8'd192, 8'd182};

    bus.req      = '0;
    bus.din1_bus = '0;
    bus.din2_bus = '0;
    do_reset();

    // Single request: 4*4
    set_op(0, 8'd4, 8'd4);
    expect_op(0, 8'd4, 8'd4, 8'd16, 1'b0);
    busy_cnt = 0;
    bus.req = 4'b0001;
    wait_gnts(1, "wait_gnt_single");
    bus.req = '0;
    wait_dones(1, "wait_done_single");
    check("latency_normal", done_cyc - gnt_cyc, LAT+1);
    tick(2);
    check("busy_cycles", busy_cnt, LAT+2);
    check("busy_idle", {31'b0, bus.busy}, 32'd0);

    // All four held: round-robin 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, opa[i], opb[i]);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) expect_op(i, opa[i], opb[i], prd[i], 1'b0);
    g0 = gnt_cnt; d0 = done_cnt;
    bus.req = 4'b1111;
    wait_gnts(g0 + 8, "wait_gnt_all");
    bus.req = '0;
    wait_dones(d0 + 8, "wait_done_all");

    // Fairness between requesters 0 and 2
    do_reset();
    for (int r = 0; r < 2; r++) begin
      expect_op(0, opa[0], opb[0], prd[0], 1'b0);
      expect_op(2, opa[2], opb[2], prd[2], 1'b0);
    end
    g0 = gnt_cnt; d0 = done_cnt;
    bus.req = 4'b0101;
    wait_gnts(g0 + 4, "wait_gnt_fair");
    bus.req = '0;
    wait_dones(d0 + 4, "wait_done_fair");

    // Timeout: multiplier silent, then normal service of the next request
    do_reset();
    mute = 1'b1;
    expect_op(1, opa[1], opb[1], 8'd0, 1'b1);
    g0 = gnt_cnt; d0 = done_cnt;
    bus.req = 4'b0010;
    wait_gnts(g0 + 1, "wait_gnt_to");
    bus.req = '0;
    wait_dones(d0 + 1, "wait_done_to");
    check("latency_timeout", done_cyc - gnt_cyc, TO+1);
    mute = 1'b0;
    expect_op(3, opa[3], opb[3], prd[3], 1'b0);
    bus.req = 4'b1000;
    wait_gnts(g0 + 2, "wait_gnt_after_to");
    bus.req = '0;
    wait_dones(d0 + 2, "wait_done_after_to");

    // Spurious multiplier valid while idle
    tick(2);
    d0 = done_cnt;
    spur_dout = 8'hAA;
    spur_vld  = 1'b1;
    tick(1);
    spur_vld  = 1'b0;
    tick(3);
    check("spur_result", {24'b0, bus.result}, 32'd182);
    check("spur_no_done", done_cnt, d0);
    check("spur_busy", {31'b0, bus.busy}, 32'd0);

    // Reset during WAIT: the in-flight operation is dropped without a done
    gq.push_back('{id: 2, a: opa[2], b: opb[2]});
    g0 = gnt_cnt; d0 = done_cnt;
    bus.req = 4'b0100;
    wait_gnts(g0 + 1, "wait_gnt_rst");
    bus.req = '0;
    tick(3);
    do_reset();
    tick(LAT + 4);
    check("no_stale_done", done_cnt, d0);
    expect_op(0, opa[0], opb[0], prd[0], 1'b0);
    bus.req = 4'b1111;
    wait_gnts(g0 + 2, "wait_gnt_post_rst");
    bus.req = '0;
    wait_dones(d0 + 1, "wait_done_post_rst");

    tick(5);
    check("gq_empty", gq.size(), 32'd0);
    check("dq_empty", dq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
